// File: rtl/inst_encoder.sv
// inst_encoder: streaming RV32I instruction encoder.
// Symbolic requests (op, rd, rs1, rs2, imm) come in over a valid/ready
// handshake. Each one is packed into a 32-bit word and written to sequential
// word addresses through a held write/ack port.
// Pipeline: encode register E, then write register W. W drives the write port.
// Optional build macro INST_ENCODER_IMM_CHECK_EN turns on immediate range
// checking. Out-of-range requests are accepted, dropped, and flag err_o.
`timescale 1ns/1ps

module inst_encoder #(
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [4:0]        op_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [31:0]       imm_i,
  input  logic              start_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  input  logic              wr_ack_i,
  output logic [ADDR_W-1:0] count_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SRA  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SLL  = 5'd7;
  localparam logic [4:0] OP_SLT  = 5'd8;
  localparam logic [4:0] OP_ADDI = 5'd9;
  localparam logic [4:0] OP_SLTI = 5'd10;
  localparam logic [4:0] OP_XORI = 5'd11;
  localparam logic [4:0] OP_ORI  = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_SLLI = 5'd14;
  localparam logic [4:0] OP_SRLI = 5'd15;
  localparam logic [4:0] OP_SRAI = 5'd16;
  localparam logic [4:0] OP_LW   = 5'd17;
  localparam logic [4:0] OP_SW   = 5'd18;
  localparam logic [4:0] OP_BEQ  = 5'd19;
  localparam logic [4:0] OP_BNE  = 5'd20;
  localparam logic [4:0] OP_JAL  = 5'd21;
  localparam logic [4:0] OP_JALR = 5'd22;

  logic              e_valid;
  logic [31:0]       e_data;
  logic              w_valid;
  logic [31:0]       w_data;
  logic [ADDR_W-1:0] count_q;
  logic              err_q;

  logic [31:0] enc_word;
  logic        op_legal;
  logic        imm_ok;
  logic        e_adv;
  logic        w_done;
  logic        accept;
  logic        restart;

  // Pack the current request into an instruction word and flag illegal ops.
  always_comb begin
    enc_word = '0;
    op_legal = 1'b1;
    case (op_i)
      OP_ADD:  enc_word = {7'b0000000, rs2_i, rs1_i, 3'b000, rd_i, OPC_R};
      OP_SUB:  enc_word = {7'b0100000, rs2_i, rs1_i, 3'b000, rd_i, OPC_R};
      OP_AND:  enc_word = {7'b0000000, rs2_i, rs1_i, 3'b111, rd_i, OPC_R};
      OP_OR:   enc_word = {7'b0000000, rs2_i, rs1_i, 3'b110, rd_i, OPC_R};
      OP_XOR:  enc_word = {7'b0000000, rs2_i, rs1_i, 3'b100, rd_i, OPC_R};
      OP_SRA:  enc_word = {7'b0100000, rs2_i, rs1_i, 3'b101, rd_i, OPC_R};
      OP_SRL:  enc_word = {7'b0000000, rs2_i, rs1_i, 3'b101, rd_i, OPC_R};
      OP_SLL:  enc_word = {7'b0000000, rs2_i, rs1_i, 3'b001, rd_i, OPC_R};
      OP_SLT:  enc_word = {7'b0000000, rs2_i, rs1_i, 3'b010, rd_i, OPC_R};
      OP_ADDI: enc_word = {imm_i[11:0], rs1_i, 3'b000, rd_i, OPC_I};
      OP_SLTI: enc_word = {imm_i[11:0], rs1_i, 3'b010, rd_i, OPC_I};
      OP_XORI: enc_word = {imm_i[11:0], rs1_i, 3'b100, rd_i, OPC_I};
      OP_ORI:  enc_word = {imm_i[11:0], rs1_i, 3'b110, rd_i, OPC_I};
      OP_ANDI: enc_word = {imm_i[11:0], rs1_i, 3'b111, rd_i, OPC_I};
      OP_SLLI: enc_word = {7'b0000000, imm_i[4:0], rs1_i, 3'b001, rd_i, OPC_I};
      OP_SRLI: enc_word = {7'b0000000, imm_i[4:0], rs1_i, 3'b101, rd_i, OPC_I};
      OP_SRAI: enc_word = {7'b0100000, imm_i[4:0], rs1_i, 3'b101, rd_i, OPC_I};
      OP_LW:   enc_word = {imm_i[11:0], rs1_i, 3'b010, rd_i, OPC_LOAD};
      OP_SW:   enc_word = {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0], OPC_STORE};
      OP_BEQ:  enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, 3'b000,
                           imm_i[4:1], imm_i[11], OPC_BR};
      OP_BNE:  enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, 3'b001,
                           imm_i[4:1], imm_i[11], OPC_BR};
      OP_JAL:  enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                           rd_i, OPC_JAL};
      OP_JALR: enc_word = {imm_i[11:0], rs1_i, 3'b000, rd_i, OPC_JALR};
      default: op_legal = 1'b0;
    endcase
  end

`ifdef INST_ENCODER_IMM_CHECK_EN
  logic signed [31:0] imm_s;
  logic               fits_12;
  logic               fits_br;
  logic               fits_jal;

  assign imm_s    = $signed(imm_i);
  assign fits_12  = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
  assign fits_br  = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm_i[0];
  assign fits_jal = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !imm_i[0];

  // Range-check the immediate against the field it is packed into.
  always_comb begin
    imm_ok = 1'b1;
    case (op_i)
      OP_ADDI, OP_SLTI, OP_XORI, OP_ORI, OP_ANDI,
      OP_LW, OP_SW, OP_JALR:     imm_ok = fits_12;
      OP_SLLI, OP_SRLI, OP_SRAI: imm_ok = (imm_i[31:5] == 27'd0);
      OP_BEQ, OP_BNE:            imm_ok = fits_br;
      OP_JAL:                    imm_ok = fits_jal;
      default:                   imm_ok = 1'b1;
    endcase
  end
`else
  // Without checking, immediates are simply truncated to their field.
  logic unused_imm;
  assign imm_ok     = 1'b1;
  assign unused_imm = ^{imm_i[31:21], imm_i[0]};
`endif

  // E moves into W when W is free or W is being acknowledged right now.
  assign e_adv       = e_valid && (!w_valid || wr_ack_i);
  assign w_done      = w_valid && wr_ack_i;
  assign req_ready_o = !start_i && (!e_valid || e_adv);
  assign accept      = req_valid_i && req_ready_o;
  assign restart     = start_i && !busy_o;

  assign busy_o    = e_valid || w_valid;
  assign wr_en_o   = w_valid;
  assign wr_data_o = w_data;
  assign wr_addr_o = BASE + count_q;
  assign count_o   = count_q;
  assign err_o     = err_q;

  // Two-stage word pipeline; W holds its word until acknowledged.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid <= 1'b0;
      e_data  <= '0;
      w_valid <= 1'b0;
      w_data  <= '0;
    end else begin
      if (e_adv) begin
        w_valid <= 1'b1;
        w_data  <= e_data;
      end else if (w_done) begin
        w_valid <= 1'b0;
      end

      if (accept && op_legal && imm_ok) begin
        e_valid <= 1'b1;
        e_data  <= enc_word;
      end else if (e_adv) begin
        e_valid <= 1'b0;
      end
    end
  end

  // Write counter and sticky error; restart clears both only when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (restart) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (w_done) count_q <= count_q + 1'b1;
      if (accept && !(op_legal && imm_ok)) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
`timescale 1ns/1ps

module tb_inst_encoder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  op, rd, rs1, rs2;
  logic [31:0] imm;
  logic        start;
  logic        wr_en;
  logic [29:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic [29:0] count;
  logic        err;
  logic        busy;

  logic        s_req_valid;
  logic        s_req_ready;
  logic        s_start;
  logic        s_wr_en;
  logic [3:0]  s_wr_addr;
  logic [31:0] s_wr_data;
  logic        s_wr_ack;
  logic [3:0]  s_count;
  logic        s_err;
  logic        s_busy;

  inst_encoder dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op_i(op), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
    .start_i(start),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_ack_i(wr_ack),
    .count_o(count), .err_o(err), .busy_o(busy)
  );

  inst_encoder #(.BASE_ADDR(14), .ADDR_W(4)) dut_s (
    .clk(clk), .rst(rst),
    .req_valid_i(s_req_valid), .req_ready_o(s_req_ready),
    .op_i(op), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
    .start_i(s_start),
    .wr_en_o(s_wr_en), .wr_addr_o(s_wr_addr), .wr_data_o(s_wr_data), .wr_ack_i(s_wr_ack),
    .count_o(s_count), .err_o(s_err), .busy_o(s_busy)
  );

  localparam int BASE = 0;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [61:0] exp_q[$];
  int          push_idx;
  int          n_written;
  logic [31:0] cur_exp;
  bit          cur_legal;
  bit          acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // One clock: score writes and acceptances at the falling edge, then step.
  task automatic cycle();
    logic [61:0] e;
    @(negedge clk);
    if (!rst && wr_en && wr_ack) begin
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e[61:32]));
        check("wr_data", wr_data, e[31:0]);
      end
      n_written++;
    end
    acc = req_valid && req_ready && !rst;
    if (acc && cur_legal) begin
      exp_q.push_back({30'(BASE + push_idx), cur_exp});
      push_idx++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [4:0] o, input logic [4:0] d, input logic [4:0] s1,
                     input logic [4:0] s2, input logic [31:0] im,
                     input logic [31:0] ex, input bit lg);
    op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
    cur_exp = ex; cur_legal = lg; req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (acc) break;
    end
    check("req_accepted", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int acc_s;
    int small_exp[3];

    rst = 1'b1; req_valid = 1'b0; op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    start = 1'b0; wr_ack = 1'b0; cur_exp = '0; cur_legal = 1'b0; acc = 1'b0;
    s_req_valid = 1'b0; s_start = 1'b0; s_wr_ack = 1'b0;
    push_idx = 0; n_written = 0;
    repeat (2) cycle();
    rst = 1'b0;

    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'(BASE));
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);

    // ADDI x1,x0,5 and its latency
    wr_ack = 1'b1;
    req(5'd9, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b1);
    req_valid = 1'b0;
    check("lat_not_yet", 32'(wr_en), 32'd0);
    cycle();
    check("lat_wr_en", 32'(wr_en), 32'd1);
    check("lat_wr_data", wr_data, 32'h0050_0093);
    cycle();
    check("addi_count", 32'(count), 32'd1);

    // back-to-back with ack held high
    req(5'd1,  5'd3, 5'd1, 5'd2, 32'd0,          32'h4020_81B3, 1'b1);
    req(5'd18, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020_A423, 1'b1);
    req(5'd19, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC,  32'hFE20_8EE3, 1'b1);
    req(5'd21, 5'd1, 5'd0, 5'd0, 32'd8,          32'h0080_00EF, 1'b1);
    req(5'd16, 5'd5, 5'd6, 5'd0, 32'd3,          32'h4033_5293, 1'b1);
    check("throughput_count", 32'(count), 32'd4);
    idle(3);
    check("b2b_count", 32'(count), 32'(n_written));
    check("b2b_drained", 32'(exp_q.size()), 32'd0);

    // backpressure: two words buffered, third stalls
    wr_ack = 1'b0;
    req(5'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0031_00B3, 1'b1);
    req(5'd3, 5'd4, 5'd5, 5'd6, 32'd0, 32'h0062_E233, 1'b1);
    op = 5'd11; rd = 5'd7; rs1 = 5'd8; rs2 = 5'd0; imm = 32'hFFFF_FFFF;
    cur_exp = 32'hFFF4_4393; cur_legal = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_ready_low", 32'(req_ready), 32'd0);
      check("bp_wr_en", 32'(wr_en), 32'd1);
      check("bp_data_stable", wr_data, exp_q[0][31:0]);
      check("bp_addr_stable", 32'(wr_addr), 32'(exp_q[0][61:32]));
    end
    wr_ack = 1'b1;
    #1;
    check("bp_ready_rise", 32'(req_ready), 32'd1);
    req(5'd11, 5'd7, 5'd8, 5'd0, 32'hFFFF_FFFF, 32'hFFF4_4393, 1'b1);
    idle(5);
    check("bp_count", 32'(count), 32'(n_written));
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // illegal op
    req(5'd25, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 1'b0);
    check("illegal_err", 32'(err), 32'd1);
    idle(3);
    check("illegal_busy", 32'(busy), 32'd0);
    check("illegal_count", 32'(count), 32'(n_written));

    // start while busy is ignored
    wr_ack = 1'b0;
    req(5'd9, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b1);
    req_valid = 1'b0;
    start = 1'b1;
    #1;
    check("start_blocks_ready", 32'(req_ready), 32'd0);
    cycle();
    start = 1'b0;
    check("start_busy_err", 32'(err), 32'd1);
    check("start_busy_count", 32'(count), 32'(n_written));
    check("start_busy_busy", 32'(busy), 32'd1);
    wr_ack = 1'b1;
    idle(4);

    // start while idle restarts
    start = 1'b1;
    cycle();
    start = 1'b0;
    push_idx = 0; n_written = 0;
    check("start_idle_err", 32'(err), 32'd0);
    check("start_idle_count", 32'(count), 32'd0);
    check("start_idle_addr", 32'(wr_addr), 32'(BASE));

    // ADDI with out-of-range immediate
`ifdef INST_ENCODER_IMM_CHECK_EN
    req(5'd9, 5'd1, 5'd0, 5'd0, 32'd2048, 32'd0, 1'b0);
    check("imm2048_err", 32'(err), 32'd1);
`else
    req(5'd9, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h8000_0093, 1'b1);
    check("imm2048_err", 32'(err), 32'd0);
`endif
    idle(3);
    check("imm2048_count", 32'(count), 32'(n_written));
    check("imm2048_drained", 32'(exp_q.size()), 32'd0);

    // reset with a write pending
    wr_ack = 1'b0;
    req(5'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0031_00B3, 1'b1);
    req_valid = 1'b0;
    cycle();
    check("pend_wr_en", 32'(wr_en), 32'd1);
    rst = 1'b1;
    wr_ack = 1'b1;
    cycle();
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wr_ack = 1'b0;
    exp_q.delete();
    push_idx = 0; n_written = 0;

    // narrow counter wraps: ADDR_W=4, BASE_ADDR=14
    small_exp[0] = 14; small_exp[1] = 15; small_exp[2] = 0;
    op = 5'd9; rd = 5'd1; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd1;
    s_req_valid = 1'b1; s_wr_ack = 1'b1;
    k = 0; acc_s = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (s_wr_en && s_wr_ack) begin
        if (k < 3) check("small_addr", 32'(s_wr_addr), 32'(small_exp[k]));
        k++;
      end
      if (s_req_valid && s_req_ready) acc_s++;
      @(posedge clk);
      #1;
      if (acc_s == 3) s_req_valid = 1'b0;
    end
    check("small_writes", 32'(k), 32'd3);
    check("small_count", 32'(s_count), 32'd3);

    check("final_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
